// File: rtl/mem_arb_pkg.sv
// Shared constants, tag type and width helpers for the memory arbiter.
// Imported by the interface, the round-robin sub-module and the top.
package mem_arb_pkg;

   localparam int DEF_DATA_W  = 16;
   localparam int DEF_ADDR_W  = 32;
   localparam int DEF_N_PORTS = 2;
   localparam int DEF_RD_LAT  = 1;

   // Wide enough for a port index of up to 8 requesters.
   localparam int PORT_W = 3;

   typedef struct packed {
      logic              valid;
      logic [PORT_W-1:0] port;
   } tag_t;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 16; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

   // A single-port arbiter still needs a 1-bit pointer register.
   function automatic int ptr_width(input int n);
      return (clog2(n) < 1) ? 1 : clog2(n);
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side bus of the arbiter: slave is the arbiter's view,
// master is the view of whatever drives requests and models the memory.
interface mem_arbiter_if
   import mem_arb_pkg::*;
#(
   parameter int N_PORTS = DEF_N_PORTS,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int ADDR_W  = DEF_ADDR_W
) ();

   logic [N_PORTS-1:0]        req_valid;
   logic [N_PORTS-1:0]        req_we;
   logic [N_PORTS*ADDR_W-1:0] req_addr;
   logic [N_PORTS*DATA_W-1:0] req_wdata;
   logic [N_PORTS-1:0]        stall;
   logic [N_PORTS-1:0]        rsp_valid;
   logic [DATA_W-1:0]         rsp_data;
   logic                      mem_read_enable;
   logic                      mem_write_enable;
   logic [ADDR_W-1:0]         mem_addr;
   logic [DATA_W-1:0]         mem_write_data;
   logic [DATA_W-1:0]         mem_read_data;
   logic                      mem_ready;

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, mem_read_data, mem_ready,
      output stall, rsp_valid, rsp_data,
      output mem_read_enable, mem_write_enable, mem_addr, mem_write_data
   );

   modport master (
      output req_valid, req_we, req_addr, req_wdata, mem_read_data, mem_ready,
      input  stall, rsp_valid, rsp_data,
      input  mem_read_enable, mem_write_enable, mem_addr, mem_write_data
   );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin selector: the first requester at or after rr_ptr wins, and the
// pointer moves just past the winner on every grant.
module rr_arbiter
   import mem_arb_pkg::*;
#(
   parameter int N = DEF_N_PORTS
) (
   input  logic         clk,
   input  logic         clr_n,
   input  logic [N-1:0] req,
   input  logic         en,
   output logic [N-1:0] grant
);

   localparam int PTR_W = ptr_width(N);

   logic [PTR_W-1:0] rr_ptr;
   logic [PTR_W-1:0] ptr_next;
   logic             found;

   // NOTE: every output of a combinational block gets a default before any
   // branch; a path that leaves one unassigned would infer a latch.
   always_comb begin
      grant    = '0;
      ptr_next = rr_ptr;
      found    = 1'b0;
      if (en) begin
         for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
               if (!found && req[j] && (j == (int'(rr_ptr) + i) % N)) begin
                  grant[j] = 1'b1;
                  ptr_next = PTR_W'((j + 1) % N);
                  found    = 1'b1;
               end
            end
         end
      end
   end

   // NOTE: registers take non-blocking assignments so every flop samples the
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!clr_n) rr_ptr <= '0;
      else        rr_ptr <= ptr_next;
   end

endmodule

// File: rtl/mem_arbiter.sv
// N-port round-robin arbiter onto a single memory command port, with a tag
// pipeline that routes each read response back to the port that issued it.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int N_PORTS = DEF_N_PORTS,
   parameter int RD_LAT  = DEF_RD_LAT
) (
   input  logic          clk,
   input  logic          clr_n,
   input  logic          pulse_en,
   mem_arbiter_if.slave  bus
);

   logic [N_PORTS-1:0] grant;
   logic               sel_we;
   logic [ADDR_W-1:0]  sel_addr;
   logic [DATA_W-1:0]  sel_wdata;
   logic [PORT_W-1:0]  sel_port;
   tag_t               tag_pipe [RD_LAT+1];

   // Holding the enable low in reset forces grant to zero, so stall == req_valid.
   rr_arbiter #(.N(N_PORTS)) u_rr (
      .clk   (clk),
      .clr_n (clr_n),
      .req   (bus.req_valid),
      .en    (pulse_en & bus.mem_ready & clr_n),
      .grant (grant)
   );

   assign bus.stall = bus.req_valid & ~grant;

   always_comb begin
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      sel_port  = '0;
      for (int i = 0; i < N_PORTS; i++) begin
         if (grant[i]) begin
            sel_we    = bus.req_we[i];
            sel_addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
            sel_wdata = bus.req_wdata[i*DATA_W +: DATA_W];
            sel_port  = PORT_W'(i);
         end
      end
   end

   // NOTE: the tag pipeline is reset along with the control flops; a stale
   // valid bit surviving reset would emit a phantom response.
   always_ff @(posedge clk) begin
      if (!clr_n) begin
         bus.mem_read_enable  <= 1'b0;
         bus.mem_write_enable <= 1'b0;
         bus.mem_addr         <= '0;
         bus.mem_write_data   <= '0;
         bus.rsp_valid        <= '0;
         bus.rsp_data         <= '0;
         for (int k = 0; k <= RD_LAT; k++) tag_pipe[k] <= '0;
      end else begin
         bus.mem_read_enable  <= (|grant) & ~sel_we;
         bus.mem_write_enable <= (|grant) & sel_we;
         if (|grant) begin
            bus.mem_addr       <= sel_addr;
            bus.mem_write_data <= sel_wdata;
         end

         // Stage k is valid in the k-th cycle after the read enable; the last
         // stage lines up with the cycle mem_read_data is sampled.
         tag_pipe[0].valid <= (|grant) & ~sel_we;
         tag_pipe[0].port  <= sel_port;
         for (int k = 1; k <= RD_LAT; k++) tag_pipe[k] <= tag_pipe[k-1];

         for (int i = 0; i < N_PORTS; i++) begin
            bus.rsp_valid[i] <= tag_pipe[RD_LAT].valid &&
                                (tag_pipe[RD_LAT].port == PORT_W'(i));
         end
         if (tag_pipe[RD_LAT].valid) bus.rsp_data <= bus.mem_read_data;
      end
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, memory data width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 32, memory address width in bits.
REQ-003 The block SHALL have parameter N_PORTS, default 2, requester count, legal range 1..8.
REQ-004 The block SHALL have parameter RD_LAT, default 1, memory read latency in cycles, legal range 1..4.
REQ-005 The block SHALL have one clock and a synchronous, active-low reset, and SHALL expose the following ports.
- clk  in  1  sole clock, rising edge.
- clr_n  in  1  synchronous active-low reset.
- pulse_en  in  1  global advance enable; low blocks new grants.
- req_valid  in  N_PORTS  per-port request.
- req_we  in  N_PORTS  per-port write (1) / read (0).
- req_addr  in  N_PORTS*ADDR_W  packed addresses, port 0 in LSBs.
- req_wdata  in  N_PORTS*DATA_W  packed write data.
- stall  out  N_PORTS  per-port hold request.
- rsp_valid  out  N_PORTS  one-hot read-response strobe.
- rsp_data  out  DATA_W  read response data.
- mem_read_enable  out  1  memory read strobe.
- mem_write_enable  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_write_data  out  DATA_W  memory write data.
- mem_read_data  in  DATA_W  memory read data.
- mem_ready  in  1  memory can accept a command this cycle.

Function
REQ-006 Grant SHALL be combinational: at most one port SHALL be granted per cycle, and only when pulse_en=1 and mem_ready=1.
REQ-007 Arbitration SHALL be round-robin from rr_ptr: the first requesting port at or after rr_ptr, wrapping N_PORTS-1 -> 0, SHALL win.
REQ-008 After a grant to port k, rr_ptr SHALL become (k+1) mod N_PORTS at the next edge; with no grant, rr_ptr SHALL hold.
REQ-009 stall[i] SHALL equal req_valid[i] AND NOT grant[i] in the same cycle; stall[i] SHALL be 0 when req_valid[i]=0.
REQ-010 A granted request SHALL be registered onto mem_* at the next edge: the matching enable SHALL be high for exactly one cycle, with mem_addr/mem_write_data from the granted port.
REQ-011 When no grant occurs, both enables SHALL be 0; mem_addr and mem_write_data SHALL hold their previous values.
REQ-012 For a read, mem_read_data SHALL be sampled RD_LAT cycles after the cycle in which mem_read_enable was high.
REQ-013 rsp_data SHALL be updated and rsp_valid[k] SHALL pulse one cycle after the sample, giving grant-cycle to rsp_valid latency RD_LAT+2.
REQ-014 Port tags SHALL travel in an RD_LAT+1 deep shift pipeline; one read per cycle back-to-back SHALL be supported with no outstanding limit.
REQ-015 rsp_data SHALL hold its value while rsp_valid is all-zero.
REQ-016 Writes SHALL produce no response.
REQ-017 Reads already in flight SHALL complete even if pulse_en or mem_ready is low.
REQ-018 With N_PORTS=1, the block SHALL reduce to a pass-through: grant = req_valid & pulse_en & mem_ready.

Reset
REQ-019 On clr_n=0 at a clock edge, the following SHALL be cleared: rr_ptr=0, mem_read_enable=0, mem_write_enable=0, mem_addr=0, mem_write_data=0, rsp_valid=0, rsp_data=0, and the tag pipeline.
REQ-020 While clr_n=0, grant SHALL be forced to 0 and stall SHALL equal req_valid.
REQ-021 A reset mid-read SHALL discard the in-flight read; no rsp_valid SHALL be generated for it after reset is released.

Structure
REQ-022 Shared package mem_arb_pkg SHALL hold the default DATA_W/ADDR_W/N_PORTS/RD_LAT constants and the clog2 function used for rr_ptr width.
REQ-023 Round-robin selection plus rr_ptr SHALL be a sub-module rr_arbiter (req, en in; grant, one-hot out).

Verification
REQ-024 The bench SHALL cover each of the following directed scenarios (N_PORTS=2, RD_LAT=1 unless stated).
- Single read: port0 reads 0x0000_0010 with mem_read_data=0xBEEF -> mem_read_enable in cycle t+1, rsp_valid=2'b01 and rsp_data=0xBEEF in cycle t+3.
- Contention: both ports request every cycle from reset -> grants alternate 0,1,0,1; the other port's stall=1 each cycle.
- Backpressure: mem_ready=0 for 3 cycles with both ports requesting -> stall=2'b11, no enables; first grant after release goes to port0.
- pulse_en=0 mid-stream -> no new enables; an in-flight read still returns rsp_valid.
- Reset mid-read: clr_n=0 one cycle after the enable -> no rsp_valid after release; rr_ptr=0.
- N_PORTS=4, RD_LAT=3: ports 3 and 0 request -> port0 granted first, then port3; wrap verified; read latency = 5 cycles.
